// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative RV32M divider: op select, FSM states
// and the default datapath width.
package div_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    FDIV  = 2'b00,
    FDIVU = 2'b01,
    FREM  = 2'b10,
    FREMU = 2'b11
  } funct_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift {rem,quo} left by one, then subtract the divisor if it fits.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // The shifted partial remainder can reach 2*|B|-1, so it needs WIDTH+1
  // bits, and the borrow of the subtraction one more on top of that.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    fits     = ~diff[WIDTH+1];
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Signed ops run
// on magnitudes in CALC; FIX restores the signs and registers the result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iFlush,
  input  logic [1:0]       iFunct,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH-1);

  state_e           state, state_next;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [CNT_W-1:0] cnt_q;
  logic             rem_sel_q, qsign_q, rsign_q;

  logic             accept, is_signed, is_rem, div_zero, overflow, special;
  logic [WIDTH-1:0] special_result, abs_a, abs_b, fixed_quo, fixed_rem;

  assign accept = (state == IDLE) && iStart && !iFlush;

  // Operand decode works straight off the input buses so the special cases
  // can complete on the accept edge itself.
  always_comb begin
    is_signed = ~iFunct[0];
    is_rem    = iFunct[1];
    div_zero  = (iB == '0);
    overflow  = is_signed && (iA == MIN_NEG) && (iB == '1);
    special   = div_zero || overflow;
    if (div_zero) special_result = is_rem ? iA : '1;
    else          special_result = is_rem ? '0 : MIN_NEG;
    abs_a     = (is_signed && iA[WIDTH-1]) ? -iA : iA;
    abs_b     = (is_signed && iB[WIDTH-1]) ? -iB : iB;
    fixed_quo = qsign_q ? -quo_q : quo_q;
    fixed_rem = rsign_q ? -rem_q : rem_q;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_step_in_rem()),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  function automatic logic [WIDTH-1:0] rem_step_in_rem();
    return rem_q;
  endfunction

  // NOTE: the reset here is synchronous (sampled on the clock edge), so it
  // lives inside the clocked if/else rather than in the sensitivity list.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every variable assigned in an always_comb gets a default first,
  // otherwise paths that skip it would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (iFlush) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      oResult   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_sel_q <= is_rem;
            if (special) begin
              oResult <= special_result;
            end else begin
              rem_q   <= '0;
              quo_q   <= abs_a;
              div_q   <= abs_b;
              cnt_q   <= LAST_ITER;
              qsign_q <= is_signed && (iA[WIDTH-1] ^ iB[WIDTH-1]);
              rsign_q <= is_signed && iA[WIDTH-1];
            end
          end
        end
        CALC: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        // A flush in FIX must leave the previously delivered result intact.
        FIX: if (!iFlush) oResult <= rem_sel_q ? fixed_rem : fixed_quo;
        default: ;
      endcase
    end
  end

  assign oBusy = (state == CALC) || (state == FIX);
  assign oDone = (state == DONE) && !iFlush;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   funct;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iStart  (start),
    .iFlush  (flush),
    .iFunct  (funct),
    .iA      (a),
    .iB      (b),
    .oBusy   (busy),
    .oDone   (done),
    .oResult (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural result straight from the RISC-V rules.
  function automatic logic [W-1:0] ref_result(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
    case (f)
      FDIV:    if (y == 0) return '1;
               else if (x == MIN_NEG && y == '1) return MIN_NEG;
               else return sx / sy;
      FDIVU:   if (y == 0) return '1; else return x / y;
      FREM:    if (y == 0) return x;
               else if (x == MIN_NEG && y == '1) return '0;
               else return sx % sy;
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    if (y == 0) return 1;
    if (!f[0] && x == MIN_NEG && y == '1) return 1;
    return W + 2;
  endfunction

  // Transaction-level model: an op is outstanding from accept until its
  // done cycle; the visible result changes only when an op delivers.
  int           ecnt = 0;
  bit           m_active = 1'b0;
  int           m_done_at = 0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_hold = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_hold   = '0;
    end else if (flush) begin
      if (m_active && ecnt == m_done_at) m_hold = m_result;
      m_active = 1'b0;
    end else if (m_active && ecnt == m_done_at) begin
      m_active = 1'b0;
      m_hold   = m_result;
    end else if (!m_active && start) begin
      m_active  = 1'b1;
      m_result  = ref_result(funct, a, b);
      m_done_at = ecnt + ref_latency(funct, a, b);
    end
    ecnt++;
  end

  logic exp_done, exp_busy;
  always @(negedge clk) begin
    if (checking) begin
      exp_done = m_active && (ecnt == m_done_at) && !flush;
      exp_busy = m_active && (ecnt < m_done_at);
      check("cyc_busy", busy, exp_busy);
      check("cyc_done", done, exp_done);
      check("cyc_result", result, exp_done ? m_result : m_hold);
    end
  end

  task automatic issue(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    start = 1'b1; funct = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // first_cyc: relative cycle number (accept edge = 0) of the next negedge.
  task automatic wait_done(input logic [W-1:0] exp, input int exp_lat, input string name, input int first_cyc);
    int lat;
    lat = -1;
    for (int i = first_cyc; i <= 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no oDone within 60 cycles, expected cycle %0d", name, exp_lat);
    end else begin
      check($sformatf("%s_latency", name), lat, exp_lat);
      check($sformatf("%s_result", name), result, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp, input int exp_lat, input string name);
    issue(f, x, y);
    wait_done(exp, exp_lat, name, 1);
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = MIN_NEG;
      3:       v = W'($urandom_range(0, 15));
      4:       v = -W'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct = FDIVU; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);

    check("model_divu", ref_result(FDIVU, 100, 7), 14);
    check("model_rem_neg", ref_result(FREM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    check("model_div_ovf", ref_result(FDIV, MIN_NEG, '1), MIN_NEG);
    check("model_lat_zero", ref_latency(FREMU, 5, 0), 1);

    run_op(FDIVU, 100, 7, 14, 34, "divu_100_7");
    run_op(FREMU, 100, 7, 2, 34, "remu_100_7");
    run_op(FDIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(FREM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run_op(FDIV, 5, 0, 32'hFFFF_FFFF, 1, "div_by_zero");
    run_op(FREMU, 5, 0, 5, 1, "remu_by_zero");
    run_op(FDIV, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1, "div_overflow");
    run_op(FREM, MIN_NEG, 32'hFFFF_FFFF, 0, 1, "rem_overflow");

    // A second request while busy must be ignored.
    issue(FDIVU, 1000, 10);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; funct = FREM; a = 7; b = 3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(100, 34, "busy_ignore", 6);

    // Flush in cycle 10: back to IDLE, previous result retained.
    issue(FDIVU, 50, 5);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 0);
    check("flush_result_kept", result, 100);
    run_op(FDIVU, 77, 7, 11, 34, "after_flush");

    // Reset in cycle 20 of an operation.
    issue(FDIVU, 12345, 3);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_result", result, 0);
    run_op(FDIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 34, "after_reset");

    // Random traffic: requests at arbitrary times (also while busy/done)
    // and occasional flushes; the per-cycle compare does the checking.
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 99) == 0);
      funct = 2'($urandom_range(0, 3));
      a     = rand_operand();
      b     = rand_operand();
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU).
- Replaces the single-cycle combinational divide path in the EX stage.
- Sits beside the ALU and takes the same operand buses.
- Control stalls the pipeline while oBusy is high; the writeback mux selects oResult when oDone pulses.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥ 2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- iCLK  input  1  clock; all state updates on rising edge.
- iRST  input  1  reset, synchronous, active-high.
- iStart  input  1  request; accepted only in IDLE.
- iFlush  input  1  pipeline flush; aborts any operation in progress.
- iFunct  input  2  op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- iA  input  WIDTH  dividend.
- iB  input  WIDTH  divisor.
- oBusy  output  1  high from the cycle after accept until oDone.
- oDone  output  1  one-cycle pulse; oResult is valid in that cycle.
- oResult  output  WIDTH  quotient or remainder; held until the next accept.

Behaviour:
- Reset (iRST=1 at an edge): state=IDLE; oBusy=0, oDone=0, oResult=0; counter and internal registers cleared. Reset dominates every other input, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - iStart=1 and iFlush=0 → latch iFunct, iA, iB.
  - Special case detected → go to DONE.
  - Otherwise → take magnitudes (signed ops), record quotient sign = sA^sB and remainder sign = sA, clear the partial remainder, set counter=WIDTH-1, go to CALC.
- CALC:
  - Each cycle, shift {rem,quo} left by 1, bringing in the next dividend MSB.
  - If rem ≥ |B|: subtract |B| and set quo[0]=1.
  - Decrement the counter. After the counter=0 iteration, go to FIX. That is exactly WIDTH cycles in CALC.
- FIX:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (signed ops only).
  - Register the selected result into oResult; go to DONE.
- DONE: oDone=1 for this one cycle; next state IDLE. A new iStart is not accepted in DONE.
- Latency, with the accept edge as cycle 0:
  - Normal op: oDone high in cycle WIDTH+2 (34 for WIDTH=32).
  - Special case: oDone high in cycle 1.
- oBusy = (state ≠ IDLE) and (state ≠ DONE).
- Special cases (RISC-V spec; no trap):
  - B=0: DIV/DIVU give all-ones; REM/REMU give A.
  - DIV with A=100…0, B=all-ones: result 100…0. REM with the same operands: result 0.
- iStart while not IDLE: ignored. The operand registers are not disturbed.
- iFlush in any state: next state IDLE; no oDone pulse; oResult keeps its previous value.
  - iFlush together with iStart in IDLE: the request is dropped.
  - iRST and iFlush together: reset behaviour applies.
- Unsigned ops use the raw operands; no sign correction in FIX.
- All width arithmetic is WIDTH bits. The subtract compare uses a WIDTH+1-bit difference so no carry is lost.

Decomposition:
- Shared package holds:
  - iFunct encodings: FDIV=2'b00, FDIVU=2'b01, FREM=2'b10, FREMU=2'b11.
  - State encoding: IDLE, CALC, FIX, DONE.
  - Default WIDTH.
- One natural sub-module, div_step: the combinational restoring step. It takes rem, quo, |B| and produces the next rem and quo. It is instantiated once inside the CALC datapath so it can be exhaustively unit-tested at small WIDTH.
- The FSM and sign handling stay in div_unit.

Test Plan:
- DIVU, A=100, B=7, single iStart → oDone in cycle 34, oResult=14. Repeat with REMU → oResult=2.
- DIV, A=-7 (0xFFFFFFF9), B=2 → oResult=0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1); the remainder sign follows the dividend.
- Special cases, each with oDone in cycle 1:
  - DIV, B=0, A=5 → 0xFFFFFFFF.
  - REMU, B=0, A=5 → 5.
  - DIV, A=0x80000000, B=0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Busy handling: accept DIVU 1000/10, then pulse iStart with different operands in cycle 5 → ignored; oResult=100 at cycle 34; oBusy=1 in cycles 1–33.
- Flush: iFlush in cycle 10 of an operation → IDLE next cycle, no oDone, oResult unchanged (previous value). A new request issued immediately afterwards completes normally.
- Reset mid-operation: iRST in cycle 20 → next cycle oBusy=0, oDone=0, oResult=0. Then DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF in cycle 34.
